// File: rtl/sfp_drain_pkg.sv
// Shared constants, helper functions and serializer state type for sfp_drain.
package sfp_drain_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } ser_state_t;

  function automatic int lanes_per_beat(input int out_bw, input int psum_bw);
    return out_bw / psum_bw;
  endfunction

  function automatic int beats_per_row(input int col, input int lpb);
    return col / lpb;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sfp_row_fifo.sv
// Row FIFO with an occupancy counter; the head entry is visible combinationally on rd_data.
module sfp_row_fifo #(
  parameter int width = 128,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [width-1:0]             rd_data,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);

  logic [width-1:0] r_mem [depth];
  logic [aw-1:0]    r_wr_ptr;
  logic [aw-1:0]    r_rd_ptr;
  logic [cw-1:0]    r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full    = (r_count == cw'(depth));
  assign empty   = (r_count == '0);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  // Storage needs no reset: nothing is read until the count says it was written.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sfp_drain.sv
// Captures core rows into a small FIFO and serializes them as out_bw-wide beats on a valid/ready stream.
//   state    | meaning
//   ST_EMPTY | no row in the serializer, out_valid low
//   ST_SEND  | row register holds a row, presenting beat r_beat
module sfp_drain
  import sfp_drain_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int out_bw  = 32,
  parameter int depth   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [col*psum_bw-1:0]              sfp_out,
  input  logic                                sfp_valid,
  output logic                                sfp_ready,
  output logic [out_bw-1:0]                   out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic [count_width(depth)-1:0]       fifo_count,
  output logic                                overflow,
  input  logic                                clear_ovf
);

  localparam int lpb   = lanes_per_beat(out_bw, psum_bw);
  localparam int beats = beats_per_row(col, lpb);
  localparam int row_w = col * psum_bw;
  localparam int cw    = count_width(depth);
  localparam int bw    = (beats > 1) ? $clog2(beats) : 1;

  ser_state_t        r_state;
  ser_state_t        w_state_nxt;
  logic [row_w-1:0]  r_row;
  logic [bw-1:0]     r_beat;
  logic [bw-1:0]     w_beat_nxt;
  logic [out_bw-1:0] r_out_data;
  logic              r_out_last;
  logic              r_overflow;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [row_w-1:0]  w_head;
  logic [cw-1:0]     w_count;
  logic              w_wr;
  logic              w_drop;
  logic              w_pop;
  logic              w_adv;
  logic              w_to_empty;
  logic              w_last_beat;
  logic [row_w-1:0]  w_src_row;
  logic [out_bw-1:0] w_data_nxt;
  logic              w_last_nxt;

  // Ready depends only on occupancy, so a full FIFO refuses a write even on a popping edge.
  assign sfp_ready = !w_fifo_full;
  assign w_wr      = sfp_valid && !w_fifo_full;
  assign w_drop    = sfp_valid && w_fifo_full;

  sfp_row_fifo #(
    .width (row_w),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr),
    .wr_data (sfp_out),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (w_count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign w_last_beat = (r_beat == bw'(beats - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_pop       = 1'b0;
    w_adv       = 1'b0;
    w_to_empty  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (!w_last_beat) begin
            w_adv      = 1'b1;
            w_beat_nxt = r_beat + 1'b1;
          end else if (!w_fifo_empty) begin
            w_pop      = 1'b1;
            w_beat_nxt = '0;
          end else begin
            w_to_empty  = 1'b1;
            w_state_nxt = ST_EMPTY;
          end
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // The next beat is sliced from the FIFO head on a pop, otherwise from the held row.
  assign w_src_row  = w_pop ? w_head : r_row;
  assign w_data_nxt = w_src_row[int'(w_beat_nxt)*out_bw +: out_bw];
  assign w_last_nxt = (w_beat_nxt == bw'(beats - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row      <= '0;
      r_beat     <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (w_pop) r_row <= w_head;
      if (w_pop || w_adv) begin
        r_beat     <= w_beat_nxt;
        r_out_data <= w_data_nxt;
        r_out_last <= w_last_nxt;
      end else if (w_to_empty) begin
        r_out_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (clear_ovf) r_overflow <= 1'b0;
  end

  assign out_valid  = (r_state == ST_SEND);
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign fifo_count = w_count;
  assign overflow   = r_overflow;

endmodule

// File: doc/sfp_drain.md
Name: sfp_drain

Overview:
- Downstream stage of each core; consumes the core's sfp_out row vector (col lanes × psum_bw).
- Captures a row on a strobe from the core controller and buffers it in a small row FIFO.
- Serializes each row into out_bw-wide beats over a valid/ready stream toward the host/output memory.
- Flags rows dropped because the FIFO was full.

Parameters:
- psum_bw, 16: width of one sfp_out lane (signed).
- col, 8: lanes per row; sfp_out width = col*psum_bw.
- out_bw, 32: host beat width; must be a multiple of psum_bw and divide col*psum_bw.
- depth, 4: row FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high; clears all state.
- sfp_out  in  col*psum_bw  row from the core; lane 0 occupies bits [psum_bw-1:0].
- sfp_valid  in  1  capture strobe; row is sampled on a rising edge when sfp_valid=1.
- sfp_ready  out  1  FIFO not full.
- out_data  out  out_bw  current beat.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host accepts the beat.
- out_last  out  1  high on the final beat of a row.
- fifo_count  out  clog2(depth+1)  rows waiting in the FIFO (excludes the row in the serializer).
- overflow  out  1  sticky; set when a row is dropped.
- clear_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Derived constants:
  - LPB = out_bw/psum_bw (lanes per beat).
  - BEATS = col/LPB. Defaults give LPB=2, BEATS=4.
- Reset values: sfp_ready=1, out_data=0, out_valid=0, out_last=0, fifo_count=0, overflow=0. FIFO pointers, beat index and serializer-full flag are all 0.
- Capture:
  - A write occurs on an edge when sfp_valid && sfp_ready.
  - sfp_ready = (fifo_count != depth). It is not combinationally relieved by a same-cycle pop, so a full FIFO refuses a write even while popping.
- Drop: sfp_valid && !sfp_ready on an edge sets overflow and discards the row.
- overflow priority: clear_ovf=1 clears overflow on the edge, unless a drop occurs on the same edge, in which case overflow stays 1.
- Serializer states:
  - EMPTY: out_valid=0. If the FIFO is non-empty, pop the head into the row register, set beat=0, and go to SEND.
  - SEND: out_valid=1, out_data = lanes [beat*LPB .. beat*LPB+LPB-1], lowest lane in the LSBs, bits passed through unchanged. out_last = (beat == BEATS-1).
  - On out_valid && out_ready:
    - If not the last beat: beat increments.
    - On the last beat with the FIFO non-empty: pop the next row on the same edge, set beat=0, stay in SEND. No bubble between rows.
    - On the last beat with the FIFO empty: go to EMPTY.
- Stream protocol: out_data and out_last are registered and held stable while out_valid && !out_ready. out_valid never drops without a handshake.
- Latency: a row captured at edge E0 into an empty FIFO with an EMPTY serializer is popped at E1. out_valid=1 with beat 0 from E1.
- Throughput: one beat per cycle with out_ready held high; BEATS cycles per row.
- Simultaneous write and pop:
  - fifo_count is unchanged.
  - Writing to an empty FIFO while the serializer pops on the same edge is illegal by construction: an empty FIFO is never popped.
- Pointer wrap: write and read pointers have clog2(depth) bits and wrap naturally. Full/empty are determined by fifo_count.
- Reset mid-row: the in-flight row and all queued rows are discarded. out_valid drops asynchronously and there is no partial-row resumption.

Decomposition:
- Package sfp_drain_pkg: function computing LPB and BEATS from the parameters, count width clog2(depth+1), and the serializer state enum (EMPTY, SEND).
- Sub-module sfp_row_fifo:
  - Parameterized width/depth synchronous FIFO.
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Asynchronous active-high reset.
  - Read data is available at the head combinationally.
- sfp_drain instantiates one sfp_row_fifo plus the serializer FSM.

Test Plan:
- Single row, defaults:
  - Stimulus: lanes 0..7 = 0x0001..0x0008 with one sfp_valid pulse; out_ready=1.
  - Required: out_valid high from the cycle after the pop edge; beats 0x00020001, 0x00040003, 0x00060005, 0x00080007; out_last only on the 4th beat; then out_valid=0.
- Backpressure:
  - Stimulus: same row; out_ready toggles 1,0,0,1,...
  - Required: out_data and out_last held stable during the 0 cycles; the beat sequence is identical.
- Fill and overflow:
  - Stimulus: out_ready=0; 6 consecutive sfp_valid pulses with rows R0..R5.
  - Required: R0 goes to the serializer; R1..R4 fill the FIFO (fifo_count=4, sfp_ready=0); R5 is dropped; overflow=1.
  - Then: out_ready=1 drains R0..R4 in order, 20 beats with no gaps at row boundaries.
- clear_ovf:
  - Stimulus: clear_ovf asserted alone.
  - Required: overflow returns to 0.
  - Stimulus: clear_ovf asserted on the same edge as a drop.
  - Required: overflow stays 1.
- Streaming:
  - Stimulus: a new row every 4 cycles with out_ready=1, 16 rows.
  - Required: out_valid continuously high after start; overflow stays 0; fifo_count ≤ 1.
- Reset mid-row:
  - Stimulus: assert reset after beat 1 of a row, with 2 rows queued.
  - Required: out_valid=0 immediately; fifo_count=0; after release, no stale beats appear. A new row is then output correctly.
